alu_reservation_station: RTL and testbench

- Operand-collecting issue queue directly upstream of the integer ALU.
- Accepts decoded ALU ops from dispatch, whose operands may still be pending on producer tags.
- Snoops the common data bus (CDB) to capture operands as they are produced.
- Issues the oldest op with both operands present to the ALU inputs (lhs/rhs, lhs_valid/rhs_valid, uses_imm, funct3, funct7) plus its destination tag.

---
 rtl/alu_reservation_station.sv | 175 +++++++++++++++++
 tb/tb_alu_reservation_station.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_reservation_station.sv
// rtl/alu_reservation_station.sv - age-ordered operand-collecting issue queue feeding the integer ALU
// Optional CDB-to-issue bypass: define ALU_RS_WAKEUP_BYPASS_EN.
module alu_reservation_station #(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH  = 4,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         disp_valid,
  output logic                         disp_ready,
  input  logic [TAG_WIDTH-1:0]         disp_tag,
  input  logic [DATA_WIDTH-1:0]        disp_lhs,
  input  logic [DATA_WIDTH-1:0]        disp_rhs,
  input  logic                         disp_lhs_valid,
  input  logic                         disp_rhs_valid,
  input  logic [TAG_WIDTH-1:0]         disp_lhs_tag,
  input  logic [TAG_WIDTH-1:0]         disp_rhs_tag,
  input  logic                         disp_uses_imm,
  input  logic [2:0]                   disp_funct3,
  input  logic [6:0]                   disp_funct7,
  input  logic                         cdb_valid,
  input  logic [TAG_WIDTH-1:0]         cdb_tag,
  input  logic [DATA_WIDTH-1:0]        cdb_data,
  output logic                         issue_valid,
  input  logic                         issue_ready,
  output logic [DATA_WIDTH-1:0]        issue_lhs,
  output logic [DATA_WIDTH-1:0]        issue_rhs,
  output logic                         issue_lhs_valid,
  output logic                         issue_rhs_valid,
  output logic                         issue_uses_imm,
  output logic [2:0]                   issue_funct3,
  output logic [6:0]                   issue_funct7,
  output logic [TAG_WIDTH-1:0]         issue_tag,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic                  busy;
    logic [DATA_WIDTH-1:0] lhs;
    logic [DATA_WIDTH-1:0] rhs;
    logic                  lv;
    logic                  rv;
    logic [TAG_WIDTH-1:0]  ltag;
    logic [TAG_WIDTH-1:0]  rtag;
    logic                  imm;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [TAG_WIDTH-1:0]  dtag;
  } entry_t;

  entry_t         ent_q [DEPTH];
  entry_t         ent_w [DEPTH];
  entry_t         ent_s [DEPTH];
  entry_t         ent_d [DEPTH];
  entry_t         disp_e;
  entry_t         sel_e;
  logic [CW-1:0]  count_q;
  logic [CW-1:0]  count_d;
  logic [CW-1:0]  survivors;
  logic [IW-1:0]  sel;
  logic           any_elig;
  logic           issue_fire;
  logic           disp_fire;

  // Capture a broadcast result into any still-pending operand of a live entry.
  function automatic entry_t wake(input entry_t e, input logic cv,
                                  input logic [TAG_WIDTH-1:0] ct,
                                  input logic [DATA_WIDTH-1:0] cd);
    entry_t r;
    r = e;
    if (e.busy && cv && !e.lv && e.ltag == ct) begin
      r.lhs = cd;
      r.lv  = 1'b1;
    end
    if (e.busy && cv && !e.rv && e.rtag == ct) begin
      r.rhs = cd;
      r.rv  = 1'b1;
    end
    return r;
  endfunction

  always_comb begin
    disp_e      = '0;
    disp_e.busy = 1'b1;
    disp_e.lhs  = disp_lhs;
    disp_e.rhs  = disp_rhs;
    disp_e.lv   = disp_lhs_valid;
    disp_e.rv   = disp_rhs_valid;
    disp_e.ltag = disp_lhs_tag;
    disp_e.rtag = disp_rhs_tag;
    disp_e.imm  = disp_uses_imm;
    disp_e.f3   = disp_funct3;
    disp_e.f7   = disp_funct7;
    disp_e.dtag = disp_tag;
    disp_e      = wake(disp_e, cdb_valid, cdb_tag, cdb_data);
  end

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_w[i] = wake(ent_q[i], cdb_valid, cdb_tag, cdb_data);
`ifdef ALU_RS_WAKEUP_BYPASS_EN
      ent_s[i] = ent_w[i];
`else
      ent_s[i] = ent_q[i];
`endif
    end
  end

  // Oldest eligible entry wins; scan from youngest so the lowest index sticks.
  always_comb begin
    sel      = '0;
    any_elig = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_s[i].busy && ent_s[i].lv && ent_s[i].rv) begin
        sel      = IW'(i);
        any_elig = 1'b1;
      end
    end
  end

  always_comb begin
    sel_e = '0;
    if (any_elig) sel_e = ent_s[sel];
  end

  assign issue_valid     = any_elig;
  assign issue_lhs       = sel_e.lhs;
  assign issue_rhs       = sel_e.rhs;
  assign issue_lhs_valid = any_elig;
  assign issue_rhs_valid = any_elig;
  assign issue_uses_imm  = sel_e.imm;
  assign issue_funct3    = sel_e.f3;
  assign issue_funct7    = sel_e.f7;
  assign issue_tag       = sel_e.dtag;

  assign disp_ready = (count_q < CW'(DEPTH));
  assign count      = count_q;
  assign issue_fire = any_elig && issue_ready && !flush;
  assign disp_fire  = disp_valid && disp_ready && !flush;
  assign survivors  = count_q - CW'(issue_fire);

  // Compact over the issued slot, then append the dispatched op behind the survivors.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = '0;
      if (issue_fire && i >= int'(sel)) begin
        if (i + 1 < DEPTH) ent_d[i] = ent_w[(i + 1) % DEPTH];
      end else begin
        ent_d[i] = ent_w[i];
      end
      if (disp_fire && CW'(i) == survivors) ent_d[i] = disp_e;
    end
    count_d = count_q + CW'(disp_fire) - CW'(issue_fire);
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) ent_d[i] = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_alu_reservation_station.sv
// tb/tb_alu_reservation_station.sv - directed self-checking bench for alu_reservation_station
module tb_alu_reservation_station;
  logic        clk = 1'b0;
  logic        rst, flush, disp_valid, disp_ready;
  logic [3:0]  disp_tag, disp_lhs_tag, disp_rhs_tag;
  logic [63:0] disp_lhs, disp_rhs;
  logic        disp_lhs_valid, disp_rhs_valid, disp_uses_imm;
  logic [2:0]  disp_funct3;
  logic [6:0]  disp_funct7;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [63:0] cdb_data;
  logic        issue_valid, issue_ready, issue_lhs_valid, issue_rhs_valid, issue_uses_imm;
  logic [63:0] issue_lhs, issue_rhs;
  logic [2:0]  issue_funct3;
  logic [6:0]  issue_funct7;
  logic [3:0]  issue_tag;
  logic [2:0]  count;
  int          tests = 0;
  int          failed = 0;

  alu_reservation_station #(.DATA_WIDTH(64), .TAG_WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .disp_lhs(disp_lhs), .disp_rhs(disp_rhs),
    .disp_lhs_valid(disp_lhs_valid), .disp_rhs_valid(disp_rhs_valid),
    .disp_lhs_tag(disp_lhs_tag), .disp_rhs_tag(disp_rhs_tag),
    .disp_uses_imm(disp_uses_imm), .disp_funct3(disp_funct3), .disp_funct7(disp_funct7),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_lhs(issue_lhs), .issue_rhs(issue_rhs),
    .issue_lhs_valid(issue_lhs_valid), .issue_rhs_valid(issue_rhs_valid),
    .issue_uses_imm(issue_uses_imm), .issue_funct3(issue_funct3), .issue_funct7(issue_funct7),
    .issue_tag(issue_tag), .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input logic [3:0] tag, input logic [63:0] lhs, input logic lv,
                      input logic [3:0] ltag, input logic [63:0] rhs, input logic rv,
                      input logic [3:0] rtag);
    disp_valid     = 1'b1;
    disp_tag       = tag;
    disp_lhs       = lhs;
    disp_lhs_valid = lv;
    disp_lhs_tag   = ltag;
    disp_rhs       = rhs;
    disp_rhs_valid = rv;
    disp_rhs_tag   = rtag;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; disp_valid = 1'b0; disp_tag = '0;
    disp_lhs = '0; disp_rhs = '0; disp_lhs_valid = 1'b0; disp_rhs_valid = 1'b0;
    disp_lhs_tag = '0; disp_rhs_tag = '0; disp_uses_imm = 1'b0;
    disp_funct3 = '0; disp_funct7 = '0;
    cdb_valid = 1'b0; cdb_tag = '0; cdb_data = '0; issue_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    check("rst_count", count, 0);
    check("rst_issue_valid", issue_valid, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_payload", issue_lhs, 0);

    // both operands ready: issue next cycle
    issue_ready = 1'b1;
    disp(4'd3, 64'h10, 1'b1, 4'd0, 64'h20, 1'b1, 4'd0);
    disp_funct3 = 3'd0; disp_funct7 = 7'h20; disp_uses_imm = 1'b1;
    step();
    disp_valid = 1'b0;
    check("t1_valid", issue_valid, 1);
    check("t1_lhs", issue_lhs, 64'h10);
    check("t1_rhs", issue_rhs, 64'h20);
    check("t1_tag", issue_tag, 3);
    check("t1_f7", issue_funct7, 7'h20);
    check("t1_imm", issue_uses_imm, 1);
    check("t1_lv", issue_lhs_valid, 1);
    disp_uses_imm = 1'b0; disp_funct7 = '0;
    step();
    check("t1_count0", count, 0);
    check("t1_idle", issue_valid, 0);

    // rhs pending on tag 7, woken by CDB
    disp(4'd1, 64'h1, 1'b1, 4'd0, 64'h0, 1'b0, 4'd7);
    step();
    disp_valid = 1'b0;
    check("t2_wait", issue_valid, 0);
    check("t2_count", count, 1);
    step(); step(); step();
    check("t2_still_wait", issue_valid, 0);
    cdb_valid = 1'b1; cdb_tag = 4'd7; cdb_data = 64'hDEAD;
`ifdef ALU_RS_WAKEUP_BYPASS_EN
    #1;
    check("t2_byp_valid", issue_valid, 1);
    check("t2_byp_rhs", issue_rhs, 64'hDEAD);
    step();
    cdb_valid = 1'b0;
    check("t2_count0", count, 0);
`else
    step();
    cdb_valid = 1'b0;
    check("t2_valid", issue_valid, 1);
    check("t2_rhs", issue_rhs, 64'hDEAD);
    check("t2_tag", issue_tag, 1);
    step();
    check("t2_count0", count, 0);
`endif

    // dispatch / CDB same-cycle race
    disp(4'd6, 64'h0, 1'b0, 4'd5, 64'h3, 1'b1, 4'd0);
    cdb_valid = 1'b1; cdb_tag = 4'd5; cdb_data = 64'h55;
    step();
    disp_valid = 1'b0; cdb_valid = 1'b0;
    check("t3_valid", issue_valid, 1);
    check("t3_lhs", issue_lhs, 64'h55);
    check("t3_tag", issue_tag, 6);
    step();
    check("t3_count0", count, 0);

    // fill, refuse while full even when issuing, then drain in order
    issue_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      disp(4'(k), 64'h100 + 64'(k), 1'b1, 4'd0, 64'h0, 1'b1, 4'd0);
      step();
    end
    disp_valid = 1'b0;
    check("t4_full_count", count, 4);
    check("t4_full_ready", disp_ready, 0);
    check("t4_head", issue_tag, 0);
    disp(4'd9, 64'h999, 1'b1, 4'd0, 64'h0, 1'b1, 4'd0);
    issue_ready = 1'b1;
    step();
    disp_valid = 1'b0;
    check("t4_refused", count, 3);
    for (int k = 1; k < 4; k++) begin
      check($sformatf("t4_order%0d", k), issue_tag, 4'(k));
      check($sformatf("t4_lhs%0d", k), issue_lhs, 64'h100 + 64'(k));
      step();
    end
    check("t4_drained", count, 0);
    check("t4_idle", issue_valid, 0);

    // younger ready op overtakes older waiting op
    issue_ready = 1'b0;
    disp(4'd2, 64'h0, 1'b0, 4'd9, 64'h7, 1'b1, 4'd0);
    step();
    disp(4'd4, 64'h44, 1'b1, 4'd0, 64'h4, 1'b1, 4'd0);
    step();
    disp_valid = 1'b0;
    check("t5_b_first", issue_tag, 4);
    issue_ready = 1'b1;
    step();
    check("t5_a_wait", issue_valid, 0);
    check("t5_count1", count, 1);
    cdb_valid = 1'b1; cdb_tag = 4'd9; cdb_data = 64'h99;
    step();
    cdb_valid = 1'b0;
`ifndef ALU_RS_WAKEUP_BYPASS_EN
    check("t5_a_tag", issue_tag, 2);
    check("t5_a_lhs", issue_lhs, 64'h99);
    step();
`endif
    check("t5_count0", count, 0);

    // flush drops dispatch in the same cycle
    issue_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      disp(4'(10 + k), 64'h1, 1'b1, 4'd0, 64'h2, 1'b1, 4'd0);
      step();
    end
    check("t6_count3", count, 3);
    disp(4'd13, 64'h1, 1'b1, 4'd0, 64'h2, 1'b1, 4'd0);
    flush = 1'b1; issue_ready = 1'b1;
    step();
    flush = 1'b0; disp_valid = 1'b0;
    check("t6_flush_count", count, 0);
    check("t6_flush_valid", issue_valid, 0);
    step();
    check("t6_no_late_op", count, 0);

    // reset mid-operation
    issue_ready = 1'b0;
    disp(4'd5, 64'h1, 1'b1, 4'd0, 64'h2, 1'b1, 4'd0);
    step(); step();
    disp_valid = 1'b0;
    check("t7_pre_count", count, 2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t7_rst_count", count, 0);
    check("t7_rst_valid", issue_valid, 0);
    check("t7_rst_ready", disp_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
